// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI constants and writer state encoding
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Bursts must never cross this byte boundary
  localparam int BOUNDARY_4K = 4096;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } wr_state_t;

endpackage

// File: rtl/axi_burst_len_calc.sv
// rtl/axi_burst_len_calc.sv - beats in next burst: min(remaining, max burst, words to 4 KB)
module axi_burst_len_calc
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH    = 16,
  parameter int LEN_WIDTH     = 16,
  parameter int STRB_WIDTH    = 4,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [LEN_WIDTH-1:0]  remaining,
  output logic [8:0]            beats
);

  localparam int SIZE_LOG2 = $clog2(STRB_WIDTH);

  logic [31:0] room;
  logic [31:0] n;

  // Clamp the burst by the three limits; 32-bit math keeps width handling simple
  always_comb begin
    room = (32'(BOUNDARY_4K) - (32'(addr) & 32'(BOUNDARY_4K - 1))) >> SIZE_LOG2;
    n    = 32'(MAX_BURST_LEN);
    if (room < n) n = room;
    if (32'(remaining) < n) n = 32'(remaining);
    beats = 9'(n);
  end

endmodule

// File: rtl/axis_axi_burst_writer.sv
// rtl/axis_axi_burst_writer.sv - AXI-Stream to AXI4 INCR burst writer; AXIS_AXI_BURST_WRITER_PERF_EN adds stall_cycles
module axis_axi_burst_writer
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int ID_WIDTH      = 8,
  parameter int AWID_VALUE    = 0,
  parameter int MAX_BURST_LEN = 16,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
`ifdef AXIS_AXI_BURST_WRITER_PERF_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int SIZE_LOG2 = $clog2(STRB_WIDTH);

  wr_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic [7:0]            beat_q;
  logic [7:0]            awlen_q;
  logic                  done_q;
  logic                  error_q;
  logic [8:0]            burst_beats;
  logic [7:0]            awlen_c;
  logic                  w_fire;
  logic                  last_word;
  logic                  unused_bid;

  axi_burst_len_calc #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .LEN_WIDTH     (LEN_WIDTH),
    .STRB_WIDTH    (STRB_WIDTH),
    .MAX_BURST_LEN (MAX_BURST_LEN)
  ) u_len_calc (
    .addr      (addr_q),
    .remaining (remaining_q),
    .beats     (burst_beats)
  );

  assign awlen_c    = 8'(burst_beats - 9'd1);
  assign w_fire     = (state_q == ST_W) && s_axis_tvalid && m_axi_wready;
  assign last_word  = (remaining_q == LEN_WIDTH'(1));
  assign unused_bid = ^m_axi_bid;

  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign error         = error_q;
  assign m_axi_awid    = ID_WIDTH'(AWID_VALUE);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = awlen_c;
  assign m_axi_awsize  = 3'(SIZE_LOG2);
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_wstrb   = '1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake outputs; W phase is a pure pass-through of the stream
  always_comb begin
    state_d       = state_q;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    s_axis_tready = 1'b0;
    m_axi_bready  = 1'b0;
    case (state_q)
      ST_IDLE: if (start && word_count != '0) state_d = ST_AW;
      ST_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_d = ST_W;
      end
      ST_W: begin
        m_axi_wvalid  = s_axis_tvalid;
        s_axis_tready = m_axi_wready;
        m_axi_wlast   = (beat_q == awlen_q);
        if (w_fire && beat_q == awlen_q) state_d = ST_B;
      end
      ST_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_d = (remaining_q != '0) ? ST_AW : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address/length bookkeeping, completion pulse and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      remaining_q <= '0;
      beat_q      <= '0;
      awlen_q     <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      done_q <= ((state_q == ST_IDLE) && start && word_count == '0) ||
                ((state_q == ST_B) && m_axi_bvalid && remaining_q == '0);
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            error_q <= 1'b0;
            if (word_count != '0) begin
              addr_q      <= start_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
              remaining_q <= word_count;
            end
          end
        end
        ST_AW: begin
          if (m_axi_awready) begin
            awlen_q <= awlen_c;
            beat_q  <= '0;
          end
        end
        ST_W: begin
          if (w_fire) begin
            addr_q      <= addr_q + ADDR_WIDTH'(STRB_WIDTH);
            remaining_q <= remaining_q - LEN_WIDTH'(1);
            beat_q      <= beat_q + 8'd1;
            if (s_axis_tlast != last_word) error_q <= 1'b1;
          end
        end
        ST_B: begin
          if (m_axi_bvalid && m_axi_bresp != RESP_OKAY) error_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef AXIS_AXI_BURST_WRITER_PERF_EN
  logic [31:0] stall_q;

  // Saturating count of W-phase cycles without a beat transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                            stall_q <= '0;
    else if (state_q == ST_IDLE && start)               stall_q <= '0;
    else if (state_q == ST_W && !w_fire && stall_q != '1) stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles = stall_q;
`endif

endmodule
